// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port; each grant covers up to MAX_BURST beats.
// One idle cycle to arbitrate. wr_en/req_ready are combinational and stall while fifo_full is set.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          wr_clk,
   input  logic                          wr_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          wr_en,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          grant_vld,
   output logic [ID_WIDTH-1:0]           grant_id
);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state;
   logic [CNT_W-1:0]      beat_cnt;
   logic [DATA_WIDTH-1:0] slice [NUM_REQ];
   logic [ID_WIDTH-1:0]   winner;
   logic [ID_WIDTH-1:0]   cand;
   logic                  in_burst;
   logic                  xfer;
   logic                  last_beat;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Gating with wr_rst drops the outputs in the very cycle reset is asserted mid-burst.
   assign in_burst  = (state == BURST) && !wr_rst;
   assign xfer      = in_burst && req_valid[grant_id] && !fifo_full;
   assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));
   assign wr_en     = xfer;
   assign wr_data   = in_burst ? slice[grant_id] : '0;

   always_comb begin
      req_ready = '0;
      if (in_burst && !fifo_full)
         req_ready[grant_id] = 1'b1;
   end

   // Scan from the farthest offset down so the nearest valid requester after grant_id wins.
   always_comb begin
      winner = grant_id;
      cand   = grant_id;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_WIDTH'((32'(grant_id) + k) % NUM_REQ);
         if (req_valid[cand])
            winner = cand;
      end
   end

   always_ff @(posedge wr_clk) begin
      if (wr_rst) begin
         state     <= IDLE;
         grant_vld <= 1'b0;
         grant_id  <= ID_WIDTH'(NUM_REQ - 1);
         beat_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  state     <= BURST;
                  grant_vld <= 1'b1;
                  grant_id  <= winner;
                  beat_cnt  <= '0;
               end
            end
            BURST: begin
               if (!req_valid[grant_id]) begin
                  state     <= IDLE;
                  grant_vld <= 1'b0;
               end else if (!fifo_full) begin
                  if (last_beat) begin
                     state     <= IDLE;
                     grant_vld <= 1'b0;
                     beat_cnt  <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state     <= IDLE;
               grant_vld <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a behavioural model.
// A second instance with MAX_BURST=1 checks single-beat alternation.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      vld;
   logic [N-1:0]      rdy;
   logic [N*DW-1:0]   rdat;
   logic              full;
   logic              wen;
   logic [DW-1:0]     wdat;
   logic              gv;
   logic [1:0]        gid;

   logic [N-1:0]      v1 = 4'b0101;
   logic [N*DW-1:0]   d1 = 32'h44332211;
   logic              full1 = 1'b0;
   logic [N-1:0]      rdy1;
   logic              en1;
   logic [DW-1:0]     wd1;
   logic              gv1;
   logic [1:0]        gid1;

   logic [DW-1:0]     dat [N];
   int                left [N];
   int                start [N];
   logic [N-1:0]      acc;
   int                cyc, full_from, full_len, rst_at;
   bit                rnd, rst_force;
   int                own, ptr, beats;
   int                wcount;
   logic [15:0]       hist;
   logic [19:0]       gseq;
   logic              gv_prev;
   int                n_chk, n_pass;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_WIDTH(2)) dut (
      .wr_clk(clk), .wr_rst(rst), .req_valid(vld), .req_data(rdat), .req_ready(rdy),
      .fifo_full(full), .wr_en(wen), .wr_data(wdat), .grant_vld(gv), .grant_id(gid));

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1), .ID_WIDTH(2)) dut1 (
      .wr_clk(clk), .wr_rst(rst), .req_valid(v1), .req_data(d1), .req_ready(rdy1),
      .fifo_full(full1), .wr_en(en1), .wr_data(wd1), .grant_vld(gv1), .grant_id(gid1));

   always #5 clk = ~clk;

   always_comb begin
      rdat = '0;
      for (int i = 0; i < N; i++)
         rdat[i*DW +: DW] = dat[i];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
      else
         n_pass++;
   endtask

   // Requesters keep valid high until accepted; otherwise they may drop or raise it freely.
   task automatic drive();
      rst  = rst_force || (!rnd && cyc == rst_at) || (rnd && $urandom_range(99) == 0);
      full = rnd ? ($urandom_range(3) == 0) : (cyc >= full_from && cyc < full_from + full_len);
      for (int i = 0; i < N; i++)
         if (!(vld[i] && !acc[i]))
            vld[i] = (left[i] > 0) && (cyc >= start[i]) && (!rnd || $urandom_range(3) != 0);
   endtask

   task automatic tick();
      logic          exp_en;
      logic [N-1:0]  exp_rdy;
      logic [DW-1:0] exp_d;
      int            w;
      #2;
      exp_en  = 1'b0;
      exp_rdy = '0;
      exp_d   = '0;
      if (!rst && own >= 0) begin
         exp_d = dat[own];
         if (!full) begin
            exp_rdy[own] = 1'b1;
            exp_en       = vld[own];
         end
      end
      check_eq("wr_en",     32'(wen),  32'(exp_en));
      check_eq("wr_data",   32'(wdat), 32'(exp_d));
      check_eq("req_ready", 32'(rdy),  32'(exp_rdy));
      check_eq("grant_vld", 32'(gv),   32'(own >= 0));
      check_eq("grant_id",  32'(gid),  32'(ptr));
      acc  = vld & rdy;
      if (wen) wcount++;
      hist = {hist[14:0], wen};
      if (gv && !gv_prev) gseq = {gseq[15:0], 2'b00, gid};
      gv_prev = gv;
      // Reference: owner is the granted requester (-1 when none), ptr the round-robin pointer.
      if (rst) begin
         own = -1; ptr = N - 1; beats = 0;
      end else if (own < 0) begin
         w = -1;
         for (int k = N; k >= 1; k--)
            if (vld[(ptr + k) % N]) w = (ptr + k) % N;
         if (w >= 0) begin
            own = w; ptr = w; beats = 0;
         end
      end else if (!vld[own]) begin
         own = -1;
      end else if (!full) begin
         beats++;
         if (beats == MB) own = -1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++)
         if (acc[i]) begin
            dat[i] = dat[i] + 8'd1;
            left[i]--;
         end
      drive();
   endtask

   task automatic do_reset();
      rst_force = 1'b1;
      for (int i = 0; i < N; i++) left[i] = 0;
      drive();
      tick();
      tick();
   endtask

   task automatic begin_scn();
      rst_force = 1'b0; rnd = 1'b0;
      full_from = -1; full_len = 0; rst_at = -1;
      cyc = 0; vld = '0; acc = '0;
      wcount = 0; hist = '0; gseq = '0;
      for (int i = 0; i < N; i++) begin
         left[i] = 0; start[i] = 0;
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst = 1'b1; full = 1'b0; vld = '0; acc = '0;
      rst_force = 1'b1; rnd = 1'b0; cyc = 0;
      full_from = -1; full_len = 0; rst_at = -1;
      for (int i = 0; i < N; i++) begin
         dat[i] = '0; left[i] = 0; start[i] = 0;
      end
      @(posedge clk);
      @(negedge clk);
      own = -1; ptr = N - 1; beats = 0;
      gv_prev = 1'b0; hist = '0; gseq = '0; wcount = 0;

      // Single requester 2 streaming 0xA0..0xA5
      do_reset();
      begin_scn();
      left[2] = 6; dat[2] = 8'hA0;
      drive();
      repeat (10) tick();
      check_eq("s1_wr_en_pattern", 32'(hist[9:2]), 32'h7B);
      check_eq("s1_writes", 32'(wcount), 32'd6);

      // All four requesters valid: rotation 0,1,2,3,0
      do_reset();
      begin_scn();
      for (int i = 0; i < N; i++) begin
         left[i] = 4; dat[i] = 8'(8'h10 * (i + 1));
      end
      left[0] = 8;
      drive();
      repeat (26) tick();
      check_eq("s2_writes", 32'(wcount), 32'd20);
      check_eq("s2_grant_seq", 32'(gseq), 32'h01230);

      // Full stall for 5 cycles after beat 2 of requester 1
      do_reset();
      begin_scn();
      left[1] = 4; dat[1] = 8'h50;
      full_from = 3; full_len = 5;
      drive();
      repeat (12) tick();
      check_eq("s3_writes", 32'(wcount), 32'd4);

      // Early release by requester 3, wrap to requester 0
      do_reset();
      begin_scn();
      left[3] = 2; dat[3] = 8'h70;
      left[0] = 3; dat[0] = 8'h00; start[0] = 1;
      drive();
      repeat (10) tick();
      check_eq("s4_writes", 32'(wcount), 32'd5);
      check_eq("s4_grant_seq", 32'(gseq[7:0]), 32'h30);

      // Reset during beat 2 of requester 0
      do_reset();
      begin_scn();
      left[0] = 6; dat[0] = 8'hC0; rst_at = 2;
      drive();
      repeat (12) tick();
      check_eq("s5_writes", 32'(wcount), 32'd6);

      // Random traffic, full and occasional reset
      do_reset();
      begin_scn();
      rnd = 1'b1;
      for (int i = 0; i < N; i++) begin
         left[i] = 100000; dat[i] = 8'(i * 64);
      end
      drive();
      repeat (3000) tick();

      // MAX_BURST=1 instance: requesters 0 and 2 alternate with single beats
      do_reset();
      begin_scn();
      drive();
      for (int k = 0; k < 8; k++) begin
         #1;
         check_eq("mb1_wr_en", 32'(en1), 32'(k % 2));
         if (k % 2 == 1) begin
            check_eq("mb1_grant_id", 32'(gid1), ((k / 2) % 2 == 0) ? 32'd0 : 32'd2);
            check_eq("mb1_wr_data",  32'(wd1),  ((k / 2) % 2 == 0) ? 32'h11 : 32'h33);
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the write side of the asynchronous FIFO among NUM_REQ requesters in the write clock domain. A requester holds the grant for a burst of up to MAX_BURST beats. Each requester sees a valid/ready handshake. The block drives the FIFO's wr_en/wr_data directly and obeys its full flag.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, width of each data word; must match the FIFO DATA_WIDTH
MAX_BURST, 4, maximum beats per grant (>=1)
ID_WIDTH, 2, width of grant_id; must equal clog2(NUM_REQ)

Ports:
wr_clk  input  1  write-domain clock; all logic on rising edge
wr_rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester data valid
req_data  input  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept (combinational)
fifo_full  input  1  full flag from the FIFO write side
wr_en  output  1  FIFO write enable (combinational)
wr_data  output  DATA_WIDTH  FIFO write data (combinational)
grant_vld  output  1  registered; high while in BURST
grant_id  output  ID_WIDTH  registered index of the current or last granted requester

Behaviour:
- Interface: one clock, wr_clk. Reset wr_rst is synchronous and active-high.
- Reset values: state=IDLE, grant_vld=0, grant_id=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0.
- While in reset or IDLE: req_ready=0, wr_en=0, wr_data=0.
- Transfer (beat) condition: state==BURST && req_valid[grant_id] && !fifo_full.
- req_ready[i] = (state==BURST) && (i==grant_id) && !fifo_full. All other ready bits are 0.
- wr_en = transfer condition.
- wr_data = req_data slice of grant_id when state==BURST, else 0.
- FSM IDLE:
  - If any req_valid is set, search from (grant_id+1) mod NUM_REQ upward with wrap. The first set bit is the winner.
  - Next edge: grant_id<=winner, beat_cnt<=0, state<=BURST.
  - No transfer happens in IDLE. Arbitration latency is one cycle.
- FSM BURST:
  - On each transfer, beat_cnt increments.
  - If a transfer occurs with beat_cnt==MAX_BURST-1: state<=IDLE. grant_id holds as the round-robin pointer.
  - If req_valid[grant_id]==0: state<=IDLE the same edge, with no transfer. An idle requester gives up the grant.
  - If fifo_full=1 with valid high: stall. State and beat_cnt hold, no transfer, and the grant is kept.
- A non-granted requester's valid has no effect until the next IDLE arbitration.
- Requester rule: once req_valid is high with ready low, the requester holds valid and data stable until ready. The arbiter does not check this.
- beat_cnt width is clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1 at a decision point.
- MAX_BURST=1: every grant is exactly one beat and IDLE is re-entered after each beat.
- Fairness: with all requesters continuously valid and fifo_full=0, grants rotate 0,1,...,NUM_REQ-1,0,...
  - Each grant yields MAX_BURST writes, then one IDLE cycle.
  - Throughput is MAX_BURST/(MAX_BURST+1).
- Reset asserted mid-burst: on that edge the block returns to reset values. wr_en and req_ready fall combinationally while wr_rst is high.
  - The partial burst is abandoned; the FIFO keeps the beats already written.
- fifo_full rising exactly on the last beat: no transfer, no exit. The beat completes when full clears.

Test Plan:
- Reset then single requester: req_valid=4'b0100 with data 0xA0..0xA5, fifo_full=0.
  - IDLE 1 cycle, then grant_id=2 and 4 writes (0xA0..0xA3), then IDLE 1 cycle.
  - Then re-grant to 2 and write 0xA4, 0xA5. wr_en pattern is 0,1,1,1,1,0,1,1.
- All four valid continuously, MAX_BURST=4: grant_id sequence 0,1,2,3,0.
  - Each grant gives exactly 4 wr_en pulses separated by 1 idle cycle.
  - wr_data equals each requester's stream in order.
- Full stall: grant to requester 1, assert fifo_full after beat 2 for 5 cycles.
  - wr_en=0 and req_ready=0 for those 5 cycles; grant_vld stays 1.
  - Beats 3-4 follow after full clears. Total of 4 writes, no data lost or duplicated.
- Early release: requester 3 valid for 2 beats then drops.
  - 2 writes, then IDLE on the cycle valid drops.
  - The next winner is requester 0 (wrap), given requester 0 is valid.
- Reset mid-burst: wr_rst high for 1 cycle during beat 2 of requester 0's grant.
  - wr_en=0 that cycle, and grant_vld=0 and grant_id=3 afterwards.
  - Requester 0 is the next winner when valid.
- MAX_BURST=1, requesters 0 and 2 valid: grants alternate 0,2,0,2.
  - One write per grant, wr_en pattern 0,1,0,1,...
